saturn_bus_program_sequencer: RTL and testbench

Downstream of the control unit. Captures the 5-bit bus program the control unit writes into a 31-entry program buffer. Replays the program nibble-by-nibble onto the Saturn bus. Returns read nibbles to the control unit and reports busy while it is sequencing.

---
 rtl/saturn_bus_program_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_saturn_bus_program_sequencer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/saturn_bus_program_sequencer.sv
// Saturn bus program sequencer: captures a 5-bit bus program from the control unit and
// replays it nibble-by-nibble onto the bus. Optional read watchdog: SATURN_BUS_WATCHDOG_EN.
module saturn_bus_program_sequencer #(
    parameter int PROG_DEPTH = 31
`ifdef SATURN_BUS_WATCHDOG_EN
    ,
    parameter int WDOG_READS = 256
`endif
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_phases,
    input  logic       i_debug_cycle,
    input  logic [4:0] i_program_data,
    input  logic [4:0] i_program_address,
    input  logic       i_no_read,
    input  logic [3:0] i_bus_nibble,
    output logic       o_bus_strobe,
    output logic       o_bus_cmd,
    output logic [3:0] o_bus_data,
    output logic       o_bus_busy,
    output logic [3:0] o_nibble,
    output logic       o_nibble_valid,
    output logic       o_error
);

    localparam logic [4:0] IDLE_ADDR = 5'd31;
    localparam logic [3:0] PC_READ   = 4'h2;
    localparam logic [3:0] DP_READ   = 4'h3;

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_READ} state_t;

    state_t     state_q, state_d;
    logic [4:0] prog_len_q, prog_len_d;
    logic [4:0] exec_ptr_q, exec_ptr_d;
    logic [4:0] last_addr_q, last_addr_d;
    logic       last_read_cmd_q, last_read_cmd_d;
    logic       strobe_q, strobe_d;
    logic       cmd_q, cmd_d;
    logic [3:0] data_q, data_d;
    logic [3:0] nibble_q, nibble_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
`ifdef SATURN_BUS_WATCHDOG_EN
    logic [7:0] wdog_cnt_q, wdog_cnt_d;
`endif

    logic [4:0] prog_mem [PROG_DEPTH];
    logic [4:0] entry;
    logic [4:0] wr_len;
    logic       write_det;
    logic       mem_we;
    logic       phase3_unused;

    assign phase3_unused = i_phases[3];
    assign entry         = prog_mem[exec_ptr_q];
    assign wr_len        = i_program_address + 5'd1;
    assign write_det     = !i_debug_cycle && (i_program_address != last_addr_q) &&
                           (i_program_address != IDLE_ADDR);
    // Writes landing while the program is being replayed are dropped and flagged.
    assign mem_we        = write_det && (state_q != S_SEND);

    // NOTE: the program buffer has no reset; a reset only clears prog_len, which is
    // what makes stale entries unreachable. Resetting storage would cost a mux per bit.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            prog_mem[i_program_address] <= i_program_data;
        end
    end

    // NOTE: every _d gets a hold/idle default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d         = state_q;
        prog_len_d      = prog_len_q;
        exec_ptr_d      = exec_ptr_q;
        last_addr_d     = last_addr_q;
        last_read_cmd_d = last_read_cmd_q;
        strobe_d        = 1'b0;
        cmd_d           = cmd_q;
        data_d          = data_q;
        nibble_d        = nibble_q;
        valid_d         = 1'b0;
        error_d         = error_q;
`ifdef SATURN_BUS_WATCHDOG_EN
        wdog_cnt_d      = wdog_cnt_q;
`endif
        if (!i_debug_cycle) begin
            last_addr_d = i_program_address;
            if (mem_we) begin
                if (wr_len > prog_len_q) prog_len_d = wr_len;
                if (i_program_data[4]) begin
                    last_read_cmd_d = (i_program_data[3:0] == PC_READ) ||
                                      (i_program_data[3:0] == DP_READ);
                end
            end
            case (state_q)
                S_IDLE: begin
                    if (i_phases[0] && (prog_len_q != 5'd0) && !write_det) begin
                        state_d    = S_SEND;
                        exec_ptr_d = 5'd0;
                    end
                end
                S_SEND: begin
                    if (write_det) error_d = 1'b1;
                    if (i_phases[1]) begin
                        strobe_d   = 1'b1;
                        cmd_d      = entry[4];
                        data_d     = entry[3:0];
                        exec_ptr_d = exec_ptr_q + 5'd1;
                        if (exec_ptr_q == prog_len_q - 5'd1) begin
                            state_d    = last_read_cmd_q ? S_READ : S_IDLE;
                            prog_len_d = 5'd0;
                            exec_ptr_d = 5'd0;
`ifdef SATURN_BUS_WATCHDOG_EN
                            wdog_cnt_d = 8'd0;
`endif
                        end
                    end
                end
                S_READ: begin
                    // Ending the read stream wins over a same-cycle phase-2 read.
                    if (i_no_read) begin
                        state_d = S_IDLE;
                    end else if (i_phases[2]) begin
                        strobe_d = 1'b1;
                        cmd_d    = 1'b0;
                        nibble_d = i_bus_nibble;
                        valid_d  = 1'b1;
`ifdef SATURN_BUS_WATCHDOG_EN
                        wdog_cnt_d = wdog_cnt_q + 8'd1;
                        if (wdog_cnt_q == 8'(WDOG_READS - 1)) begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q         <= S_IDLE;
            prog_len_q      <= 5'd0;
            exec_ptr_q      <= 5'd0;
            last_addr_q     <= IDLE_ADDR;
            last_read_cmd_q <= 1'b0;
            strobe_q        <= 1'b0;
            cmd_q           <= 1'b0;
            data_q          <= 4'd0;
            nibble_q        <= 4'd0;
            valid_q         <= 1'b0;
            error_q         <= 1'b0;
`ifdef SATURN_BUS_WATCHDOG_EN
            wdog_cnt_q      <= 8'd0;
`endif
        end else begin
            state_q         <= state_d;
            prog_len_q      <= prog_len_d;
            exec_ptr_q      <= exec_ptr_d;
            last_addr_q     <= last_addr_d;
            last_read_cmd_q <= last_read_cmd_d;
            strobe_q        <= strobe_d;
            cmd_q           <= cmd_d;
            data_q          <= data_d;
            nibble_q        <= nibble_d;
            valid_q         <= valid_d;
            error_q         <= error_d;
`ifdef SATURN_BUS_WATCHDOG_EN
            wdog_cnt_q      <= wdog_cnt_d;
`endif
        end
    end

    assign o_bus_strobe   = strobe_q;
    assign o_bus_cmd      = cmd_q;
    assign o_bus_data     = data_q;
    assign o_bus_busy     = (state_q == S_SEND);
    assign o_nibble       = nibble_q;
    assign o_nibble_valid = valid_q;
    assign o_error        = error_q;

endmodule

// File: tb/tb_saturn_bus_program_sequencer.sv
// Randomized bench for saturn_bus_program_sequencer: a transaction-level model predicts
// which phase strobes produce bus transfers and what each transfer carries.
module tb_saturn_bus_program_sequencer;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic [3:0] i_phases;
    logic       i_debug_cycle;
    logic [4:0] i_program_data;
    logic [4:0] i_program_address;
    logic       i_no_read;
    logic [3:0] i_bus_nibble;
    logic       o_bus_strobe;
    logic       o_bus_cmd;
    logic [3:0] o_bus_data;
    logic       o_bus_busy;
    logic [3:0] o_nibble;
    logic       o_nibble_valid;
    logic       o_error;

    always #5 i_clk = ~i_clk;

    saturn_bus_program_sequencer dut (
        .i_clk             (i_clk),
        .i_reset           (i_reset),
        .i_phases          (i_phases),
        .i_debug_cycle     (i_debug_cycle),
        .i_program_data    (i_program_data),
        .i_program_address (i_program_address),
        .i_no_read         (i_no_read),
        .i_bus_nibble      (i_bus_nibble),
        .o_bus_strobe      (o_bus_strobe),
        .o_bus_cmd         (o_bus_cmd),
        .o_bus_data        (o_bus_data),
        .o_bus_busy        (o_bus_busy),
        .o_nibble          (o_nibble),
        .o_nibble_valid    (o_nibble_valid),
        .o_error           (o_error)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: program buffer contents, length, pending-read flag, sticky error.
    logic [4:0] m_mem [31];
    int         m_len;
    bit         m_last_read;
    bit         m_err;
    logic [4:0] prog_q[$];
    logic [3:0] rd_q[$];

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    function automatic logic [3:0] rand_phase();
        logic [3:0] p;
        int r;
        r = $urandom_range(0, 4);
        p = 4'b0001;
        return (r == 4) ? 4'b0000 : (p << r);
    endfunction

    function automatic logic [4:0] rand_word();
        logic [4:0] w;
        w = 5'($urandom);
        if (w[4] && (w[3:0] == 4'h2 || w[3:0] == 4'h3)) w[3] = 1'b1;
        return w;
    endfunction

    task automatic write_prog();
        foreach (prog_q[i]) begin
            i_phases          = 4'b0000;
            i_program_address = 5'(i);
            i_program_data    = prog_q[i];
            tick();
            m_mem[i] = prog_q[i];
            if (i + 1 > m_len) m_len = i + 1;
            if (prog_q[i][4]) m_last_read = (prog_q[i][3:0] == 4'h2) || (prog_q[i][3:0] == 4'h3);
        end
        i_program_address = 5'd31;
        tick();
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({o_bus_strobe, o_bus_cmd, o_bus_data, o_bus_busy, o_nibble, o_nibble_valid, o_error} !== 15'd0) begin
            bad++;
            $display("FAIL %s: outputs got %b want all zero", name,
                     {o_bus_strobe, o_bus_cmd, o_bus_data, o_bus_busy, o_nibble, o_nibble_valid, o_error});
        end
    endtask

    // Replays the current program; optional debug freeze, illegal write or reset at strobe index.
    task automatic run_send(input string name, input int dbg_at, input int err_at, input int rst_at);
        int k = 0;
        int cyc = 0;
        int dbg_left = 0;
        int len = m_len;
        bit sending = 0;
        bit dbg_done = 0;
        bit err_done = 0;
        bit dbg;
        bit exp_strobe;
        logic [3:0] ph;
        while (k < len && cyc < 3000) begin
            cyc++;
            ph  = rand_phase();
            dbg = 0;
            if (sending && k == rst_at) begin
                i_phases = ph;
                i_reset  = 1'b0;
                tick();
                i_reset  = 1'b1;
                check_outputs_zero({name, "_reset"});
                m_len = 0; m_last_read = 0; m_err = 0;
                i_phases = 4'b0000;
                return;
            end
            if (sending && k == dbg_at && !dbg_done) begin
                dbg_left = 8;
                dbg_done = 1;
            end
            if (dbg_left > 0) begin
                dbg = 1;
                dbg_left--;
            end
            i_debug_cycle = dbg;
            i_phases      = ph;
            if (sending && k == err_at && !err_done && !dbg) begin
                i_program_address = 5'(len - 1);
                i_program_data    = ~m_mem[len-1];
                err_done = 1;
                m_err    = 1;
            end else begin
                i_program_address = 5'd31;
            end
            tick();
            exp_strobe = 0;
            if (!dbg) begin
                if (!sending) begin
                    if (ph[0]) sending = 1;
                end else if (ph[1]) begin
                    exp_strobe = 1;
                    k++;
                end
            end
            total++;
            if (o_bus_strobe !== exp_strobe) begin
                bad++;
                $display("FAIL %s strobe cyc%0d: got %b want %b", name, cyc, o_bus_strobe, exp_strobe);
            end
            if (exp_strobe) begin
                total++;
                if ({o_bus_cmd, o_bus_data} !== m_mem[k-1]) begin
                    bad++;
                    $display("FAIL %s entry%0d: got %h want %h", name, k - 1, {o_bus_cmd, o_bus_data}, m_mem[k-1]);
                end
            end
            total++;
            if (o_bus_busy !== (sending && k < len)) begin
                bad++;
                $display("FAIL %s busy cyc%0d: got %b want %b", name, cyc, o_bus_busy, sending && k < len);
            end
            total++;
            if (o_error !== m_err) begin
                bad++;
                $display("FAIL %s error cyc%0d: got %b want %b", name, cyc, o_error, m_err);
            end
        end
        i_debug_cycle     = 1'b0;
        i_phases          = 4'b0000;
        i_program_address = 5'd31;
        total++;
        if (k < len) begin
            bad++;
            $display("FAIL %s timeout: got %0d strobes want %0d", name, k, len);
        end
        m_len = 0;
    endtask

    // IDLE with an empty program: any phase pattern must stay silent.
    task automatic check_idle(input string name, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            i_phases     = rand_phase();
            i_bus_nibble = 4'($urandom);
            tick();
            total++;
            if ({o_bus_strobe, o_nibble_valid, o_bus_busy} !== 3'b000) begin
                bad++;
                $display("FAIL %s cyc%0d: strobe/valid/busy got %b want 000", name, c,
                         {o_bus_strobe, o_nibble_valid, o_bus_busy});
            end
            total++;
            if (o_error !== m_err) begin
                bad++;
                $display("FAIL %s error: got %b want %b", name, o_error, m_err);
            end
        end
        i_phases = 4'b0000;
    endtask

    task automatic do_read(input string name);
        int cyc = 0;
        bit take;
        logic [3:0] ph;
        logic [3:0] nib;
        while (rd_q.size() > 0 && cyc < 500) begin
            cyc++;
            ph   = rand_phase();
            take = ph[2];
            nib  = take ? rd_q[0] : 4'($urandom);
            i_phases     = ph;
            i_bus_nibble = nib;
            i_no_read    = 1'b0;
            tick();
            if (take) void'(rd_q.pop_front());
            total++;
            if ({o_bus_strobe, o_nibble_valid, o_bus_busy} !== {take, take, 1'b0}) begin
                bad++;
                $display("FAIL %s strobe/valid/busy cyc%0d: got %b want %b", name, cyc,
                         {o_bus_strobe, o_nibble_valid, o_bus_busy}, {take, take, 1'b0});
            end
            if (take) begin
                total++;
                if ({o_bus_cmd, o_nibble} !== {1'b0, nib}) begin
                    bad++;
                    $display("FAIL %s nibble: got cmd=%b nib=%h want cmd=0 nib=%h", name, o_bus_cmd, o_nibble, nib);
                end
            end
        end
        total++;
        if (rd_q.size() != 0) begin
            bad++;
            $display("FAIL %s timeout: got %0d left want 0", name, rd_q.size());
        end
        i_phases = 4'b0000;
    endtask

    task automatic end_read(input string name, input logic [3:0] last_nib);
        i_phases     = 4'b0100;
        i_no_read    = 1'b1;
        i_bus_nibble = ~last_nib;
        tick();
        i_no_read = 1'b0;
        total++;
        if ({o_bus_strobe, o_nibble_valid, o_nibble} !== {2'b00, last_nib}) begin
            bad++;
            $display("FAIL %s no_read priority: got %b want %b", name,
                     {o_bus_strobe, o_nibble_valid, o_nibble}, {2'b00, last_nib});
        end
        for (int c = 0; c < 3; c++) begin
            i_phases = 4'b0100;
            tick();
            total++;
            if ({o_bus_strobe, o_nibble_valid} !== 2'b00) begin
                bad++;
                $display("FAIL %s after no_read: got %b want 00", name, {o_bus_strobe, o_nibble_valid});
            end
        end
        i_phases = 4'b0000;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_phases = 4'b0000; i_debug_cycle = 1'b0; i_program_data = 5'd0;
        i_program_address = 5'd31; i_no_read = 1'b0; i_bus_nibble = 4'd0;
        tick();
        tick();
        i_reset = 1'b1;
        m_len = 0; m_last_read = 0; m_err = 0;
        check_outputs_zero("reset");
        check_idle("reset_idle", 4);
    endtask

    task automatic test_send();
        int lens[3] = '{1, 31, 0};
        prog_q = {5'h16, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00};
        write_prog();
        run_send("load_pc", -1, -1, -1);
        check_idle("load_pc_idle", 4);
        lens[2] = $urandom_range(2, 30);
        foreach (lens[n]) begin
            prog_q.delete();
            prog_q.push_back({1'b1, 4'($urandom_range(4, 15))});
            for (int i = 1; i < lens[n]; i++) prog_q.push_back(rand_word());
            write_prog();
            run_send($sformatf("rand_len%0d", lens[n]), -1, -1, -1);
            check_idle("rand_idle", 4);
        end
    endtask

    task automatic test_read();
        logic [3:0] last;
        prog_q = {5'h12};
        write_prog();
        run_send("pc_read_send", -1, -1, -1);
        rd_q = {4'h3, 4'hA, 4'hF};
        do_read("pc_read");
        end_read("pc_read_end", 4'hF);
        check_idle("pc_read_idle", 4);
        prog_q = {5'h13};
        write_prog();
        run_send("dp_read_send", -1, -1, -1);
        rd_q = {4'($urandom), 4'($urandom)};
        do_read("dp_read");
        prog_q = {5'h11};
        write_prog();
        last = 4'($urandom);
        rd_q = {last};
        do_read("read_after_write");
        end_read("read_write_end", last);
        run_send("prog_written_in_read", -1, -1, -1);
        check_idle("read_write_idle", 4);
    endtask

    task automatic test_debug();
        prog_q.delete();
        prog_q.push_back(5'h1C);
        for (int i = 1; i < 10; i++) prog_q.push_back(rand_word());
        write_prog();
        run_send("debug_freeze", 3, -1, -1);
        check_idle("debug_idle", 3);
    endtask

    task automatic test_error();
        prog_q.delete();
        prog_q.push_back(5'h15);
        for (int i = 1; i < 8; i++) prog_q.push_back(rand_word());
        write_prog();
        run_send("write_in_send", -1, 2, -1);
        check_idle("error_sticky", 4);
        prog_q = {5'h17, 5'h04};
        write_prog();
        run_send("after_error", -1, -1, -1);
    endtask

    task automatic test_reset_mid_send();
        prog_q.delete();
        prog_q.push_back(5'h18);
        for (int i = 1; i < 12; i++) prog_q.push_back(rand_word());
        write_prog();
        run_send("reset_mid_send", -1, -1, 4);
        check_idle("after_reset", 40);
        prog_q = {5'h19, 5'h0A, 5'h05};
        write_prog();
        run_send("after_reset_prog", -1, -1, -1);
        check_idle("after_reset_prog_idle", 3);
    endtask

`ifdef SATURN_BUS_WATCHDOG_EN
    task automatic test_watchdog();
        prog_q = {5'h12};
        write_prog();
        run_send("wdog_send", -1, -1, -1);
        for (int i = 0; i < 256; i++) rd_q.push_back(4'($urandom));
        do_read("wdog_reads");
        m_err = 1;
        check_idle("wdog_idle", 4);
    endtask
`endif

    initial begin
        test_reset();
        test_send();
        test_read();
        test_debug();
        test_error();
        test_reset_mid_send();
`ifdef SATURN_BUS_WATCHDOG_EN
        test_watchdog();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
